// File: rtl/seq_pkg.sv
// Shared defaults and width helpers for the serial pattern detector.
package seq_pkg;

    localparam int unsigned SEQ_LEN     = 5;
    localparam logic [15:0] SEQ_PATTERN = 16'b10010;
    localparam int unsigned HIT_CNT_W   = 8;

    // Ceiling log2; callers pass max_value+1 to size a counter holding max_value.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((result < 32) && ((32'd1 << result) < value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Retriggerable pulse stretcher: out stays high for HOLD_CYCLES cycles after the last trig.
module pulse_stretch
    import seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    localparam int unsigned CNT_W      = clog2(HOLD_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic out
);

    logic [CNT_W-1:0] cnt_q;

    // A trigger during an active hold reloads the count, so the output never gaps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (trig) begin
            cnt_q <= CNT_W'(HOLD_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign out = (cnt_q != '0);

endmodule

// File: rtl/seq_detect.sv
// Serial pattern detector: samples din_db on each rising edge of step_db and flags matches.
module seq_detect
    import seq_pkg::*;
#(
    parameter int unsigned     LEN         = SEQ_LEN,
    parameter logic [LEN-1:0]  PATTERN     = SEQ_PATTERN[LEN-1:0],
    parameter bit              OVERLAP     = 1'b1,
    parameter int unsigned     HOLD_CYCLES = 50_000_000,
    localparam int unsigned    FILL_W      = clog2(LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step_db,
    input  logic                 din_db,
    output logic                 hit,
    output logic                 hit_led,
    output logic [HIT_CNT_W-1:0] hit_cnt,
    output logic [LEN-1:0]       hist,
    output logic [FILL_W-1:0]    fill_cnt
);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);

    logic                 step_q;
    logic [LEN-1:0]       hist_q;
    logic [LEN-1:0]       hist_d;
    logic [FILL_W-1:0]    fill_q;
    logic [FILL_W-1:0]    fill_inc;
    logic [HIT_CNT_W-1:0] hit_cnt_q;
    logic                 hit_q;
    logic                 strobe;
    logic                 match;

    // fill_q walks empty -> filling -> armed (LEN) and saturates there.
    always_comb begin
        strobe   = step_db & ~step_q;
        hist_d   = {hist_q[LEN-2:0], din_db};
        fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
        match    = strobe && (hist_d == PATTERN) && (fill_inc == FILL_FULL);
    end

    // step_q resets high so a switch already held at release does not count as a strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_q    <= 1'b1;
            hist_q    <= '0;
            fill_q    <= '0;
            hit_cnt_q <= '0;
            hit_q     <= 1'b0;
        end else begin
            step_q <= step_db;
            hit_q  <= match;
            if (strobe) begin
                hist_q <= hist_d;
                fill_q <= (match && !OVERLAP) ? '0 : fill_inc;
            end
            if (match) begin
                hit_cnt_q <= hit_cnt_q + HIT_CNT_W'(1);
            end
        end
    end

    pulse_stretch #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_stretch (
        .clk  (clk),
        .rst_n(rst_n),
        .trig (match),
        .out  (hit_led)
    );

    assign hit      = hit_q;
    assign hit_cnt  = hit_cnt_q;
    assign hist     = hist_q;
    assign fill_cnt = fill_q;

endmodule

// File: tb/tb_seq_detect.sv
// Bench for seq_detect: overlapping and non-overlapping instances share one stimulus stream.
module tb_seq_detect;

    localparam int HOLD = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic step_db = 1'b1;
    logic din_db = 1'b0;

    logic       hit0, led0, hit1, led1;
    logic [7:0] cnt0, cnt1;
    logic [4:0] hist0, hist1;
    logic [2:0] fill0, fill1;

    always #5 clk = ~clk;

    seq_detect #(
        .LEN(5), .PATTERN(5'b10010), .OVERLAP(1'b1), .HOLD_CYCLES(HOLD)
    ) dut_ov (
        .clk(clk), .rst_n(rst_n), .step_db(step_db), .din_db(din_db),
        .hit(hit0), .hit_led(led0), .hit_cnt(cnt0), .hist(hist0), .fill_cnt(fill0)
    );

    seq_detect #(
        .LEN(5), .PATTERN(5'b10010), .OVERLAP(1'b0), .HOLD_CYCLES(HOLD)
    ) dut_no (
        .clk(clk), .rst_n(rst_n), .step_db(step_db), .din_db(din_db),
        .hit(hit1), .hit_led(led1), .hit_cnt(cnt1), .hist(hist1), .fill_cnt(fill1)
    );

    typedef struct packed {
        logic rst;
        logic step;
        logic din;
    } stim_t;
    typedef logic [35:0] obs_t;

    stim_t stim[$];
    obs_t  sb[$];
    int    checks = 0;
    int    passed = 0;

    // Reference model state, index 0 = overlapping, 1 = non-overlapping.
    logic       m_step_q = 1'b1;
    logic [4:0] m_hist[2];
    int         m_fill[2];
    int         m_cnt[2];
    int         m_led[2];
    logic       m_hit[2];

    task automatic model_clk(input stim_t s);
        logic       strobe;
        logic [4:0] nh;
        int         nf;
        logic       match;
        strobe = s.rst && s.step && !m_step_q;
        for (int i = 0; i < 2; i++) begin
            if (!s.rst) begin
                m_hist[i] = '0; m_fill[i] = 0; m_cnt[i] = 0; m_led[i] = 0; m_hit[i] = 1'b0;
            end else begin
                m_hit[i] = 1'b0;
                if (m_led[i] > 0) m_led[i] = m_led[i] - 1;
                if (strobe) begin
                    nh    = {m_hist[i][3:0], s.din};
                    nf    = (m_fill[i] == 5) ? 5 : m_fill[i] + 1;
                    match = (nh == 5'b10010) && (nf == 5);
                    m_hist[i] = nh;
                    m_fill[i] = (match && i == 1) ? 0 : nf;
                    if (match) begin
                        m_cnt[i] = (m_cnt[i] + 1) % 256;
                        m_led[i] = HOLD;
                        m_hit[i] = 1'b1;
                    end
                end
            end
        end
        m_step_q = s.rst ? s.step : 1'b1;
    endtask

    function automatic obs_t model_obs();
        return {m_hit[0], m_led[0] != 0, 8'(m_cnt[0]), m_hist[0], 3'(m_fill[0]),
                m_hit[1], m_led[1] != 0, 8'(m_cnt[1]), m_hist[1], 3'(m_fill[1])};
    endfunction

    function automatic obs_t dut_obs();
        return {hit0, led0, cnt0, hist0, fill0, hit1, led1, cnt1, hist1, fill1};
    endfunction

    function automatic void add(input logic r, input logic s, input logic d);
        stim.push_back('{rst: r, step: s, din: d});
    endfunction

    function automatic void add_bit(input logic b);
        add(1'b1, 1'b1, b);
        add(1'b1, 1'b0, ~b);
    endfunction

    function automatic void add_bits(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) add_bit(bits[i]);
    endfunction

    function automatic void add_reset();
        add(1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0);
    endfunction

    function automatic void add_idle(input int n);
        for (int i = 0; i < n; i++) add(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    endfunction

    // Drive one cycle and push the model's expectation for the state after that edge.
    task automatic drive(input stim_t s);
        @(negedge clk);
        rst_n   = s.rst;
        step_db = s.step;
        din_db  = s.din;
        model_clk(s);
        sb.push_back(model_obs());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t exp_o, act_o;
        int   n = 0;
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) add(1'b1, 1'b1, 1'($urandom_range(0, 1)));
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            exp_o = sb.pop_front(); act_o = dut_obs(); checks++; n++;
            if (act_o !== exp_o) $display("FAIL reset cyc%0d: got %h want %h", n, act_o, exp_o);
            else passed++;
        end
        checks++;
        if ({fill0, hist0, cnt0, fill1, hist1, cnt1} !== 32'h0)
            $display("FAIL reset_held_step: fill=%0d hist=%b cnt=%0d want 0", fill0, hist0, cnt0);
        else passed++;
    endtask

    task automatic test_pattern();
        obs_t exp_o, act_o;
        int   n = 0, led_cycles = 0;
        add_reset();
        add_bits(8'b10010, 5);
        add_idle(10);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            exp_o = sb.pop_front(); act_o = dut_obs(); checks++; n++;
            if (act_o !== exp_o) $display("FAIL pattern cyc%0d: got %h want %h", n, act_o, exp_o);
            else passed++;
            if (led0) led_cycles++;
        end
        checks++;
        if (cnt0 !== 8'd1 || hist0 !== 5'b10010)
            $display("FAIL pattern_final: cnt=%0d hist=%b want 1 10010", cnt0, hist0);
        else passed++;
        checks++;
        if (led_cycles != HOLD) $display("FAIL pattern_led_len: got %0d want %0d", led_cycles, HOLD);
        else passed++;
    endtask

    task automatic test_overlap();
        obs_t exp_o, act_o;
        int   n = 0, led_cycles = 0;
        add_reset();
        add_bits(8'b10010010, 8);
        add_idle(12);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            exp_o = sb.pop_front(); act_o = dut_obs(); checks++; n++;
            if (act_o !== exp_o) $display("FAIL overlap cyc%0d: got %h want %h", n, act_o, exp_o);
            else passed++;
            if (led0) led_cycles++;
        end
        checks++;
        if (cnt0 !== 8'd2 || cnt1 !== 8'd1 || fill1 !== 3'd3)
            $display("FAIL overlap_final: cnt_ov=%0d cnt_no=%0d fill_no=%0d want 2 1 3",
                     cnt0, cnt1, fill1);
        else passed++;
        // Second hit lands 6 cycles after the first, so the LED stays lit 6 + HOLD cycles.
        checks++;
        if (led_cycles != 6 + HOLD)
            $display("FAIL overlap_retrigger: led cycles %0d want %0d", led_cycles, 6 + HOLD);
        else passed++;
    endtask

    task automatic test_held_step();
        obs_t exp_o, act_o;
        int   n = 0;
        add_reset();
        add(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 99; i++) add(1'b1, 1'b1, 1'(i % 2));
        add(1'b1, 1'b0, 1'b0);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            exp_o = sb.pop_front(); act_o = dut_obs(); checks++; n++;
            if (act_o !== exp_o) $display("FAIL held_step cyc%0d: got %h want %h", n, act_o, exp_o);
            else passed++;
        end
        checks++;
        if (fill0 !== 3'd1 || hist0 !== 5'b00001)
            $display("FAIL held_step_single: fill=%0d hist=%b want 1 00001", fill0, hist0);
        else passed++;
    endtask

    task automatic test_wrap();
        obs_t exp_o, act_o;
        int   n = 0;
        logic saw_hit = 1'b0;
        add_reset();
        add_bits(8'b10010, 5);
        for (int i = 0; i < 254; i++) add_bits(8'b010, 3);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            exp_o = sb.pop_front(); act_o = dut_obs(); checks++; n++;
            if (act_o !== exp_o) $display("FAIL wrap_fill cyc%0d: got %h want %h", n, act_o, exp_o);
            else passed++;
        end
        checks++;
        if (cnt0 !== 8'd255) $display("FAIL wrap_preload: cnt=%0d want 255", cnt0);
        else passed++;
        add_bits(8'b010, 3);
        add_idle(2);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            exp_o = sb.pop_front(); act_o = dut_obs(); checks++; n++;
            if (act_o !== exp_o) $display("FAIL wrap cyc%0d: got %h want %h", n, act_o, exp_o);
            else passed++;
            if (hit0) saw_hit = 1'b1;
        end
        checks++;
        if (cnt0 !== 8'd0 || saw_hit !== 1'b1)
            $display("FAIL wrap_final: cnt=%0d hit_seen=%b want 0 1", cnt0, saw_hit);
        else passed++;
    endtask

    task automatic test_reset_mid();
        obs_t exp_o, act_o;
        int   n = 0;
        logic saw_hit = 1'b0;
        for (int phase = 0; phase < 3; phase++) begin
            if (phase == 0) begin
                add_reset(); add_bits(8'b100, 3); add(1'b0, 1'b0, 1'b1);
            end else if (phase == 1) begin
                add(1'b1, 1'b0, 1'b0); add_bits(8'b10010, 5); add(1'b0, 1'b0, 1'b1);
            end else begin
                add(1'b1, 1'b0, 1'b0); add_bits(8'b10010, 5); add_idle(3);
            end
            while (stim.size() > 0) begin
                drive(stim.pop_front());
                exp_o = sb.pop_front(); act_o = dut_obs(); checks++; n++;
                if (act_o !== exp_o) $display("FAIL reset_mid cyc%0d: got %h want %h", n, act_o, exp_o);
                else passed++;
                if (phase == 2 && hit0 && hit1) saw_hit = 1'b1;
            end
            if (phase < 2) begin
                checks++;
                if (dut_obs() !== '0) $display("FAIL reset_mid_clear%0d: got %h want 0", phase, dut_obs());
                else passed++;
            end
        end
        checks++;
        if (saw_hit !== 1'b1 || cnt0 !== 8'd1)
            $display("FAIL reset_mid_rehit: hit_seen=%b cnt=%0d want 1 1", saw_hit, cnt0);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_hist[i] = '0; m_fill[i] = 0; m_cnt[i] = 0; m_led[i] = 0; m_hit[i] = 1'b0;
        end
        test_reset();
        test_pattern();
        test_overlap();
        test_held_step();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, checks);
        $fatal(1, "timeout");
    end

endmodule
